// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Adds two WIDTH-bit two's-complement operands (WIDTH = 4*NIBBLES) by
//   reusing one 4-bit ripple-carry slice, one nibble per step, LSB first.
//   The carry between nibbles is chained through a register. Each nibble
//   is given SETTLE cycles before its slice outputs are sampled.
//
//   Optional build macro ADDSEQ_SUB_EN adds the 'op' port (0=add, 1=sub).
//   It is latched with the operands. Subtract uses b' = ~b with an initial
//   carry of 1, so carryout then means "no borrow".
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b present
//   in_ready   operands can be accepted (IDLE only)
//   a, b       WIDTH-bit two's-complement operands
//   op         (ADDSEQ_SUB_EN only) 0=add, 1=subtract
//   out_valid  sum/carryout/overflow valid (DONE)
//   out_ready  consumer takes the result
//   sum        registered WIDTH-bit result
//   carryout   carry out of the MSB nibble
//   overflow   signed overflow of the full-width operation
//   busy       high in CALC or DONE
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  parameter int SETTLE  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
`ifdef ADDSEQ_SUB_EN
  input  logic                 op,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carryout,
  output logic                 overflow,
  output logic                 busy
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bp_r;   // b as seen by the slice (inverted for subtract)
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic [WIDTH-1:0] bp_in;
  logic             carry_init;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_co;
  logic             step_done;
  logic             last_nibble;

  // 4-bit ripple of full adders; carry propagates bit by bit.
  function automatic logic [4:0] ripple4(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       ci);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[4], s};
  endfunction

`ifdef ADDSEQ_SUB_EN
  assign bp_in      = op ? ~b : b;
  assign carry_init = op;
`else
  assign bp_in      = b;
  assign carry_init = 1'b0;
`endif

  assign slice_a                = a_r[{idx, 2'b00} +: 4];
  assign slice_b                = bp_r[{idx, 2'b00} +: 4];
  assign {slice_co, slice_sum}  = ripple4(slice_a, slice_b, carry);

  // Slice outputs are only trusted on the last settle cycle of a nibble.
  assign step_done   = (cnt == CNT_LAST);
  assign last_nibble = (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (step_done && last_nibble) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // A simultaneous in_valid is not taken here; accept happens from IDLE.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, nibble stepping and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      bp_r     <= '0;
      idx      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      bp_r  <= bp_in;
      idx   <= '0;
      cnt   <= '0;
      carry <= carry_init;
    end else if (state == CALC) begin
      if (step_done) begin
        sum[{idx, 2'b00} +: 4] <= slice_sum;
        carry                  <= slice_co;
        cnt                    <= '0;
        if (last_nibble) begin
          carryout <= slice_co;
          overflow <= (a_r[WIDTH-1] == bp_r[WIDTH-1]) &&
                      (slice_sum[3] != a_r[WIDTH-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl: directed cases plus randomized
// operands, compared against a plain-arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int SETTLE  = 2;
  localparam int W       = 4 * NIBBLES;
  localparam int LAT     = NIBBLES * SETTLE;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef ADDSEQ_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryout  (carryout),
    .overflow  (overflow),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full-width a + b' + cin, returned as {overflow, carryout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic         sub);
    logic [W-1:0] bp;
    logic [W:0]   full;
    logic         ov;
    bp   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, bp} + {{W{1'b0}}, sub};
    ov   = (x[W-1] == bp[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Present operands on a falling edge; return one falling edge after accept.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                      input string tag);
    @(negedge clk);
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    a        = ta;
    b        = tb_v;
    op       = top;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), check latency and result; optionally consume.
  task automatic wait_check(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                            input string tag, input bit consume);
    logic [W+1:0] exp;
    int lat;
    exp = model(ta, tb_v, top);
    lat = 0;
    check({tag, "/busy"}, 64'(busy), 64'd1);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(LAT));
    check({tag, "/sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, "/carryout"}, 64'(carryout), 64'(exp[W]));
    check({tag, "/overflow"}, 64'(overflow), 64'(exp[W+1]));
    check({tag, "/in_ready_busy"}, 64'(in_ready), 64'd0);
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "/released"}, 64'({out_valid, in_ready}), 64'b01);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                        input string tag);
    send(ta, tb_v, top, tag);
    wait_check(ta, tb_v, top, tag, 1'b1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;
    int           seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/outs", 64'({in_ready, out_valid, busy, carryout, overflow}), 64'b10000);
    check("rst/sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle/outs", 64'({in_ready, out_valid, busy, carryout, overflow}), 64'b10000);
      check("idle/sum", 64'(sum), 64'd0);
    end

    // Directed cases
    run_op(16'h1234, 16'h1111, 1'b0, "add_basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, "carry_chain");
    run_op(16'h0001, 16'h0001, 1'b0, "no_stale_carry");
    run_op(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    run_op(16'h8000, 16'h8000, 1'b0, "ovf_neg");

    // Backpressure: result held, new operands ignored until released
    send(16'h0102, 16'h0304, 1'b0, "bp");
    wait_check(16'h0102, 16'h0304, 1'b0, "bp", 1'b0);
    a        = 16'h1000;
    b        = 16'h2000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp/hold_flags", 64'({out_valid, in_ready, busy}), 64'b101);
      check("bp/hold_sum", 64'(sum), 64'h0406);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp/to_idle", 64'({out_valid, in_ready, busy}), 64'b010);
    @(negedge clk);
    in_valid = 1'b0;
    wait_check(16'h1000, 16'h2000, 1'b0, "bp_new", 1'b1);

    // Reset in the middle of an operation
    send(16'h00FF, 16'h0001, 1'b0, "midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst/outs", 64'({in_ready, out_valid, busy, carryout, overflow}), 64'b10000);
    check("midrst/sum", 64'(sum), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst/no_valid", 64'(seen), 64'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, "after_rst");

`ifdef ADDSEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, "sub_neg");
    run_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");
`endif

    // Randomized operands
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef ADDSEQ_SUB_EN
      rop = 1'($urandom_range(0, 1));
`else
      rop = 1'b0;
`endif
      run_op(ra, rb, rop, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that adds two WIDTH-bit two's-complement operands by reusing a single 4-bit ripple-carry slice across multiple cycles, one nibble per step. The slice is built from the same delayed-gate full adders used elsewhere in the datapath, with a carry-in. The controller latches operands, chains carry through a register, waits a fixed settle time per nibble to cover gate delay, and returns sum/carryout/overflow over a valid/ready handshake. It sits between an operand producer and a result consumer wherever a wide add is needed but area allows only one 4-bit adder.

Parameters:
NIBBLES, 4, number of 4-bit steps; operand width WIDTH = 4*NIBBLES; minimum 1.
SETTLE, 2, clock cycles allowed per nibble for the slice outputs to settle; minimum 1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands a, b present.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  first operand, two's complement.
b  input  WIDTH  second operand, two's complement.
out_valid  output  1  sum, carryout and overflow are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered result.
carryout  output  1  carry out of the MSB nibble.
overflow  output  1  signed overflow of the full-width add.
busy  output  1  high in CALC or DONE.

Behaviour:
- One clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carryout=0, overflow=0, internal index/counter/carry=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b; set idx=0, cnt=0, carry=0; go to CALC.
  - CALC: the slice sees a[idx*4+:4], b[idx*4+:4] and carry-in=carry. cnt increments each cycle.
    - When cnt==SETTLE-1, write sum[idx*4+:4], then set carry to the slice carry-out and cnt to 0.
    - If idx==NIBBLES-1, register carryout and overflow and go to DONE. Otherwise idx++.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency: out_valid rises exactly NIBBLES*SETTLE cycles after the accept edge. The default is 8.
- Overflow rule: overflow = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]). Here b' is b, or ~b when subtracting.
- Carry is cleared to 0 at accept and never leaks between operations.
- sum, carryout and overflow stay stable throughout DONE. They keep their last value in IDLE and are meaningful only while out_valid=1.
- While in CALC or DONE, in_ready=0 and in_valid is ignored.
- DONE with out_ready=1 and in_valid=1 in the same cycle: go to IDLE only. New operands are accepted on the next cycle at the earliest; there is no overlap.
- Reset mid-operation clears all state immediately. The partial result is discarded and out_valid does not assert for that operation.
- Slice outputs are sampled only at cnt==SETTLE-1, never before.

Optional Feature:
ADDSEQ_SUB_EN.
- Defined: adds port op (input, 1, 0=add, 1=subtract), latched with operands at accept. For subtract, b' = ~b and the carry register is initialised to 1 at accept. carryout then means no-borrow, and overflow uses b'.
- Not defined: no op port; the block always adds, with b'=b and initial carry 0.

Test Plan:
- Assert rst_n=0 -> in_ready=1, out_valid=0, busy=0, sum=0x0000, carryout=0, overflow=0. Release, then idle 3 cycles -> no change.
- a=0x1234, b=0x1111 accepted -> out_valid exactly 8 cycles after accept with sum=0x2345, carryout=0, overflow=0.
- a=0xFFFF, b=0x0001 -> sum=0x0000, carryout=1, overflow=0, showing the carry chaining across all 4 nibbles. Next op a=0x0001, b=0x0001 -> sum=0x0002, showing no stale carry.
- Overflow cases:
  - a=0x7FFF, b=0x0001 -> sum=0x8000, carryout=0, overflow=1.
  - a=0x8000, b=0x8000 -> sum=0x0000, carryout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> out_valid and sum held, in_ready=0, new operands not taken. Raise out_ready -> IDLE, then accept on the following cycle.
- Reset mid-op: pull rst_n low 3 cycles after accepting 0x00FF+0x0001 -> outputs 0 immediately and out_valid never rises. After release, 0x00FF+0x0001 -> sum=0x0100. With ADDSEQ_SUB_EN: a=0x0005, b=0x0007, op=1 -> sum=0xFFFE, carryout=0, overflow=0.
